// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multicycle controller and the datapath muxes it steers.
// The state enum values are what state_dbg reports.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_JAL = 3'd5,
    CLS_ILL = 3'd6
  } op_class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUB_B   = 2'd0;
  localparam logic [1:0] ALUB_4   = 2'd1;
  localparam logic [1:0] ALUB_IMM = 2'd2;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] RF_ALUOUT = 2'd0;
  localparam logic [1:0] RF_MDR    = 2'd1;
  localparam logic [1:0] RF_PC     = 2'd2;

endpackage

// File: rtl/risc_multicycle_ctrl_if.sv
// Shared memory port handshake. mem_req/mem_we/iord are held stable from the
// first request cycle until the cycle mem_ready=1 completes the access.
interface risc_multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/risc_opcode_class.sv
// Combinational opcode to instruction-class decode.
module risc_opcode_class
  import risc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    op_class = CLS_ILL;
    case (opcode)
      OP_R:      op_class = CLS_R;
      OP_I_ALU:  op_class = CLS_I;
      OP_LOAD:   op_class = CLS_LD;
      OP_STORE:  op_class = CLS_ST;
      OP_BRANCH: op_class = CLS_BR;
      OP_JAL:    op_class = CLS_JAL;
      default:   op_class = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/risc_multicycle_ctrl.sv
// Multicycle control sequencer: state register plus combinational output and
// next-state decode for fetch/decode/execute/memory/writeback.
module risc_multicycle_ctrl
  import risc_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [6:0]                    opcode,
  input  logic                          alu_zero,
  risc_multicycle_ctrl_if.master        mem,
  output logic                          ir_we,
  output logic                          pc_we,
  output logic                          ab_we,
  output logic                          aluout_we,
  output logic                          mdr_we,
  output logic                          rf_we,
  output logic                          pc_src,
  output logic [1:0]                    rf_src,
  output logic                          alu_src_a,
  output logic [1:0]                    alu_src_b,
  output logic [1:0]                    alu_op,
  output logic                          instr_done,
  output logic                          illegal_op,
  output logic [3:0]                    state_dbg
);

  state_t    state_q, state_d;
  op_class_t class_q, class_d;
  op_class_t op_class;

  logic ir_we_c, pc_we_c, ab_we_c, aluout_we_c, mdr_we_c, rf_we_c;
  logic done_c, ill_c;

  risc_opcode_class u_class (
    .opcode   (opcode),
    .op_class (op_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      class_q <= CLS_ILL;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    case (state_q)
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // Class is captured here so later IR changes cannot redirect MEM_ADDR.
        class_d = op_class;
        case (op_class)
          CLS_R:         state_d = S_EXEC_R;
          CLS_I:         state_d = S_EXEC_I;
          CLS_LD, CLS_ST: state_d = S_MEM_ADDR;
          CLS_BR:        state_d = S_BRANCH;
          CLS_JAL:       state_d = S_JAL;
          default:       state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (class_q == CLS_ST) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem.mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem.mem_ready) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.iord    = 1'b0;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    ab_we_c     = 1'b0;
    aluout_we_c = 1'b0;
    mdr_we_c    = 1'b0;
    rf_we_c     = 1'b0;
    pc_src      = 1'b0;
    rf_src      = RF_ALUOUT;
    alu_src_a   = 1'b0;
    alu_src_b   = ALUB_B;
    alu_op      = ALUOP_ADD;
    done_c      = 1'b0;
    ill_c       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = ALUB_4;
        ir_we_c     = mem.mem_ready;
        pc_we_c     = mem.mem_ready;
      end
      S_DECODE: begin
        ab_we_c     = 1'b1;
        aluout_we_c = 1'b1;
        alu_src_b   = ALUB_IMM;
        ill_c       = (op_class == CLS_ILL);
        done_c      = (op_class == CLS_ILL);
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_a   = 1'b1;
        alu_src_b   = (state_q == S_EXEC_I) ? ALUB_IMM : ALUB_B;
        alu_op      = ALUOP_FUNCT;
        aluout_we_c = 1'b1;
      end
      S_WB_ALU: begin
        rf_we_c = 1'b1;
        done_c  = 1'b1;
      end
      S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = ALUB_IMM;
        aluout_we_c = 1'b1;
      end
      S_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.iord    = 1'b1;
        mdr_we_c    = mem.mem_ready;
      end
      S_WB_MEM: begin
        rf_we_c = 1'b1;
        rf_src  = RF_MDR;
        done_c  = 1'b1;
      end
      S_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.iord    = 1'b1;
        done_c      = mem.mem_ready;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_we_c   = alu_zero;
        done_c    = 1'b1;
      end
      S_JAL: begin
        rf_we_c = 1'b1;
        rf_src  = RF_PC;
        pc_we_c = 1'b1;
        pc_src  = 1'b1;
        done_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // While reset is held the state sits in FETCH; mask enables so a ready
  // memory cannot load IR/PC during reset.
  assign ir_we      = ir_we_c     & rst_n;
  assign pc_we      = pc_we_c     & rst_n;
  assign ab_we      = ab_we_c     & rst_n;
  assign aluout_we  = aluout_we_c & rst_n;
  assign mdr_we     = mdr_we_c    & rst_n;
  assign rf_we      = rf_we_c     & rst_n;
  assign instr_done = done_c      & rst_n;
  assign illegal_op = ill_c       & rst_n;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_risc_multicycle_ctrl.sv
// Directed, table-driven bench for the multicycle controller: per-cycle input
// vectors with hand-computed state and output bundles.
module tb_risc_multicycle_ctrl;
  import risc_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       alu_zero;
  logic       ir_we, pc_we, ab_we, aluout_we, mdr_we, rf_we, pc_src;
  logic [1:0] rf_src, alu_src_b, alu_op;
  logic       alu_src_a, instr_done, illegal_op;
  logic [3:0] state_dbg;

  risc_multicycle_ctrl_if mem_if ();

  risc_multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .alu_zero   (alu_zero),
    .mem        (mem_if.master),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .ab_we      (ab_we),
    .aluout_we  (aluout_we),
    .mdr_we     (mdr_we),
    .rf_we      (rf_we),
    .pc_src     (pc_src),
    .rf_src     (rf_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  // Bundle: {req,we,iord}_{ir,pc,ab,aluout,mdr,rf}_{pc_src}_{rf_src}_{src_a}_{src_b}_{alu_op}_{done,ill}
  logic [18:0] act;
  assign act = {mem_if.mem_req, mem_if.mem_we, mem_if.iord,
                ir_we, pc_we, ab_we, aluout_we, mdr_we, rf_we,
                pc_src, rf_src, alu_src_a, alu_src_b, alu_op,
                instr_done, illegal_op};

  localparam logic [18:0] O_RST   = 19'b100_000000_0_00_0_01_00_00;
  localparam logic [18:0] O_F1    = 19'b100_110000_0_00_0_01_00_00;
  localparam logic [18:0] O_F0    = 19'b100_000000_0_00_0_01_00_00;
  localparam logic [18:0] O_DEC   = 19'b000_001100_0_00_0_10_00_00;
  localparam logic [18:0] O_DILL  = 19'b000_001100_0_00_0_10_00_11;
  localparam logic [18:0] O_EXR   = 19'b000_000100_0_00_1_00_10_00;
  localparam logic [18:0] O_EXI   = 19'b000_000100_0_00_1_10_10_00;
  localparam logic [18:0] O_WBA   = 19'b000_000001_0_00_0_00_00_10;
  localparam logic [18:0] O_MA    = 19'b000_000100_0_00_1_10_00_00;
  localparam logic [18:0] O_MRW   = 19'b101_000000_0_00_0_00_00_00;
  localparam logic [18:0] O_MRR   = 19'b101_000010_0_00_0_00_00_00;
  localparam logic [18:0] O_WBM   = 19'b000_000001_0_01_0_00_00_10;
  localparam logic [18:0] O_MWW   = 19'b111_000000_0_00_0_00_00_00;
  localparam logic [18:0] O_MWR   = 19'b111_000000_0_00_0_00_00_10;
  localparam logic [18:0] O_BR1   = 19'b000_010000_1_00_1_00_01_10;
  localparam logic [18:0] O_BR0   = 19'b000_000000_1_00_1_00_01_10;
  localparam logic [18:0] O_JAL   = 19'b000_010001_1_10_0_00_00_10;

  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_I   = 7'b0010011;
  localparam logic [6:0] C_LD  = 7'b0000011;
  localparam logic [6:0] C_ST  = 7'b0100011;
  localparam logic [6:0] C_BR  = 7'b1100011;
  localparam logic [6:0] C_JAL = 7'b1101111;
  localparam logic [6:0] C_BAD = 7'b1111111;

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic        zero;
    logic [3:0]  st;
    logic [18:0] out;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic rdy, input logic zero,
                     input state_t st, input logic [18:0] out);
    vec_t v;
    v.op = op; v.rdy = rdy; v.zero = zero; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs at the falling edge, check mid-cycle, advance.
  task automatic run_vec(input int idx, input vec_t v);
    opcode = v.op;
    mem_if.mem_ready = v.rdy;
    alu_zero = v.zero;
    #1;
    chk($sformatf("state[%0d]", idx), {28'd0, state_dbg}, {28'd0, v.st});
    chk($sformatf("outs[%0d]", idx), {13'd0, act}, {13'd0, v.out});
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    opcode = C_R;
    alu_zero = 1'b0;
    mem_if.mem_ready = 1'b1;

    // R-type, 4 cycles
    add(C_R, 1, 0, S_FETCH, O_F1);  add(C_R, 1, 0, S_DECODE, O_DEC);
    add(C_R, 1, 0, S_EXEC_R, O_EXR); add(C_R, 1, 0, S_WB_ALU, O_WBA);
    // I-ALU, 4 cycles; alu_zero and mem_ready outside memory states ignored
    add(C_I, 1, 1, S_FETCH, O_F1);  add(C_I, 1, 1, S_DECODE, O_DEC);
    add(C_I, 1, 1, S_EXEC_I, O_EXI); add(C_I, 1, 1, S_WB_ALU, O_WBA);
    // LOAD with 2 MEM_RD wait states, IR changed to STORE after DECODE
    add(C_LD, 1, 0, S_FETCH, O_F1); add(C_LD, 1, 0, S_DECODE, O_DEC);
    add(C_ST, 0, 0, S_MEM_ADDR, O_MA);
    add(C_ST, 0, 0, S_MEM_RD, O_MRW); add(C_ST, 0, 0, S_MEM_RD, O_MRW);
    add(C_ST, 1, 0, S_MEM_RD, O_MRR); add(C_ST, 1, 0, S_WB_MEM, O_WBM);
    // STORE, zero wait, 4 cycles
    add(C_ST, 1, 0, S_FETCH, O_F1); add(C_ST, 1, 0, S_DECODE, O_DEC);
    add(C_ST, 1, 0, S_MEM_ADDR, O_MA); add(C_ST, 1, 0, S_MEM_WR, O_MWR);
    // BRANCH taken / not taken
    add(C_BR, 1, 1, S_FETCH, O_F1); add(C_BR, 1, 1, S_DECODE, O_DEC);
    add(C_BR, 1, 1, S_BRANCH, O_BR1);
    add(C_BR, 1, 0, S_FETCH, O_F1); add(C_BR, 1, 0, S_DECODE, O_DEC);
    add(C_BR, 1, 0, S_BRANCH, O_BR0);
    // JAL then illegal
    add(C_JAL, 1, 0, S_FETCH, O_F1); add(C_JAL, 1, 0, S_DECODE, O_DEC);
    add(C_JAL, 1, 0, S_JAL, O_JAL);
    add(C_BAD, 1, 0, S_FETCH, O_F1); add(C_BAD, 1, 0, S_DECODE, O_DILL);
    // Fetch wait state, then R-type with no bubble after it
    add(C_R, 0, 0, S_FETCH, O_F0);  add(C_R, 1, 0, S_FETCH, O_F1);
    add(C_R, 1, 0, S_DECODE, O_DEC);
    // STORE with one MEM_WR wait
    add(C_R, 1, 0, S_EXEC_R, O_EXR); add(C_R, 1, 0, S_WB_ALU, O_WBA);
    add(C_ST, 1, 0, S_FETCH, O_F1); add(C_ST, 1, 0, S_DECODE, O_DEC);
    add(C_ST, 1, 0, S_MEM_ADDR, O_MA); add(C_ST, 0, 0, S_MEM_WR, O_MWW);
    add(C_ST, 1, 0, S_MEM_WR, O_MWR); add(C_ST, 1, 0, S_FETCH, O_F1);

    // Reset held with memory ready: no enables may fire
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", {28'd0, state_dbg}, {28'd0, S_FETCH});
    chk("rst_outs", {13'd0, act}, {13'd0, O_RST});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset mid-access: a STORE stalled in MEM_WR
    v.op = C_ST; v.zero = 0; v.rdy = 1;
    v.st = S_DECODE; v.out = O_DEC;  run_vec(100, v);
    v.st = S_MEM_ADDR; v.out = O_MA; run_vec(101, v);
    v.rdy = 0; v.st = S_MEM_WR; v.out = O_MWW; run_vec(102, v);
    mem_if.mem_ready = 1'b0;
    #1;
    chk("midacc_we_before", {31'd0, mem_if.mem_we}, 32'd1);
    #1;
    rst_n = 1'b0;
    mem_if.mem_ready = 1'b1;
    #1;
    chk("midacc_we_async", {31'd0, mem_if.mem_we}, 32'd0);
    chk("midacc_iord_async", {31'd0, mem_if.iord}, 32'd0);
    chk("midacc_state", {28'd0, state_dbg}, {28'd0, S_FETCH});
    chk("midacc_outs", {13'd0, act}, {13'd0, O_RST});
    @(negedge clk);
    rst_n = 1'b1;
    v.op = C_JAL; v.rdy = 1;
    v.st = S_FETCH;  v.out = O_F1;  run_vec(103, v);
    v.st = S_DECODE; v.out = O_DEC; run_vec(104, v);
    v.st = S_JAL;    v.out = O_JAL; run_vec(105, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
